// File: rtl/clk_div_ctrl_if.sv
// Configuration port of clk_div_ctrl: a master offers a divide ratio and the
// controller accepts it or flags it as illegal.
//
// Handshake: a transfer happens on every posedge where cfg_valid && cfg_ready.
// The master holds cfg_div stable while cfg_valid is high, and cfg_valid may be
// raised without waiting for cfg_ready. The slave's cfg_ready does not depend on
// cfg_valid. cfg_err pulses for one cycle after a transfer whose ratio was
// below 2; that ratio is dropped.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider. Ratio changes and start/stop only take
// effect on output-period boundaries, so clk_out never has a short or long period.
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    clk_div_ctrl_if.slave    cfg,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             err_q;
    logic             err_nxt;
    logic             xfer;
    logic             good;
    logic             last;
    logic             clk_out_nxt;
    logic             tick_nxt;

    // State register, together with the counter and the registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_cur  <= DIV_RST;
            pend_div <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            div_cur  <= div_nxt;
            pend_div <= pend_nxt;
            clk_out  <= clk_out_nxt;
            tick     <= tick_nxt;
            err_q    <= err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        xfer      = cfg.cfg_valid && (state != PEND);
        good      = xfer && (cfg.cfg_div >= TWO);
        err_nxt   = xfer && (cfg.cfg_div < TWO);
        last      = (state != IDLE) && (cnt == div_cur - ONE);
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div_cur;
        pend_nxt  = pend_div;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (good) begin
                    div_nxt = cfg.cfg_div;
                end
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN, PEND: begin
                if (last) begin
                    // Period boundary: the only place a ratio or a stop is applied.
                    cnt_nxt  = '0;
                    pend_nxt = '0;
                    if (state == PEND) begin
                        div_nxt = pend_div;
                    end else if (good) begin
                        div_nxt = cfg.cfg_div;
                    end
                    state_nxt = en ? RUN : IDLE;
                end else begin
                    cnt_nxt = cnt + ONE;
                    if (good) begin
                        pend_nxt  = cfg.cfg_div;
                        state_nxt = PEND;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // High time is N - floor(N/2): odd ratios get the extra cycle high.
        high_nxt    = div_nxt - (div_nxt >> 1);
        clk_out_nxt = (state_nxt != IDLE) && (cnt_nxt < high_nxt);
        tick_nxt    = (state_nxt != IDLE) && (cnt_nxt == div_nxt - ONE);
    end

    // Outputs decoded from the state register.
    always_comb begin
        cfg.cfg_ready = (state != PEND);
        cfg.cfg_err   = err_q;
        running       = (state != IDLE);
        fsm_state     = state;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable integer clock-divider controller that replaces the fixed divide-by-6 block with a run-time configurable ratio. It owns the divide counter and sequences ratio changes and start/stop so that they only take effect on output-period boundaries, which keeps the output glitch-free. A register/config master drives it through a valid/ready handshake. clk_out is a logic-generated divided clock, used as a clock enable or low-speed strobe.

Parameters:
CNT_W, 8, width of the divide ratio and of the internal counter; legal ratio N is 2 to 2^CNT_W-1.
DEFAULT_DIV, 6, ratio loaded on reset; must be at least 2.

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
en  in  1  run request; level-sensitive
cfg_valid  in  1  new ratio offered
cfg_div  in  CNT_W  offered ratio N
cfg_ready  out  1  controller can accept a ratio
cfg_err  out  1  one-cycle pulse: offered ratio rejected (less than 2)
div_cur  out  CNT_W  ratio currently in effect
clk_out  out  1  divided clock, registered
tick  out  1  one-cycle pulse in the last cycle of each period
running  out  1  high in RUN or PEND

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- States: IDLE, RUN, PEND. PEND is RUN with a ratio waiting to be applied.
- Reset (sampled at posedge) overrides everything, including mid-period and with a ratio pending. Next cycle: state IDLE, cnt=0, div_cur=DEFAULT_DIV, pending cleared, clk_out=0, tick=0, cfg_err=0, cfg_ready=1, running=0.
- Duty cycle: H = N - floor(N/2). clk_out is high while cnt is 0 to H-1 and low while cnt is H to N-1. Odd N therefore has one extra high cycle (N=5 gives 3 high, 2 low). All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - cnt=0, clk_out=0, tick=0.
  - If en=1 at an edge: go to RUN, starting with cnt=0 and clk_out=1 in the next cycle.
- RUN / PEND: cnt increments each cycle.
  - tick=1 exactly in the cycle where cnt==N-1.
  - At the edge leaving cnt==N-1 with en=1: cnt returns to 0, clk_out goes to 1, and any pending ratio is loaded into div_cur. That new period uses the new N.
  - At the edge leaving cnt==N-1 with en=0: go to IDLE with clk_out=0. Any pending ratio is still loaded into div_cur.
  - en falling mid-period does not truncate the period. The period always completes.
- Config handshake:
  - A transfer happens when cfg_valid and cfg_ready are both high at an edge.
  - cfg_ready=1 in IDLE and RUN; cfg_ready=0 in PEND, and it returns to 1 the cycle after the pending ratio is applied.
  - Accepted in IDLE: div_cur updates the next cycle.
  - Accepted in RUN: store as pending and go to PEND.
  - Accepted in RUN in the cycle where cnt==N-1: applied at that same boundary. div_cur and the new period start together, PEND is skipped and cfg_ready stays 1.
  - cfg_div below 2 on a transfer: not stored, cfg_err pulses for 1 cycle, state and div_cur unchanged.
- Width rules:
  - cnt is CNT_W bits and never exceeds N-1.
  - H is computed at CNT_W bits.
  - The N=2^CNT_W-1 boundary must not overflow.
  - div_cur never holds a value below 2.
- Mid-operation ratio change: the old period always completes at the old N; no short or long period occurs.

Test Plan:
1. Reset, then en=1 → first cycle clk_out=1; pattern is 3 high, 3 low; tick every 6 cycles in the cnt=5 cycle; div_cur=6; running=1.
2. RUN at N=6, offer cfg_div=5 at cnt=2 → cfg_ready drops the next cycle. Current period still 6 cycles; following periods are 5 (3 high, 2 low). div_cur=5 from the first cnt=0 of the new period. cfg_ready returns to 1 that cycle.
3. Offer cfg_div=1, then cfg_div=0 (IDLE and RUN) → cfg_err one-cycle pulse each time; div_cur stays 6; cfg_ready stays 1; period unaffected.
4. In IDLE set cfg_div=2 then en=1 → clk_out toggles every cycle; tick on every low cycle. Then offer cfg_div=255 at cnt==N-1 → next period is 255 cycles with 128 high; no PEND state entered.
5. RUN N=6, drop en at cnt=1 → period finishes (tick at cnt=5), then IDLE with clk_out=0 and running=0. Raise en again → restarts cleanly at cnt=0.
6. RUN N=6 with cfg_div=4 pending at cnt=4, assert reset for 1 cycle → all outputs at reset values; div_cur=6; pending discarded. Re-enable → 6-cycle periods.
